// File: rtl/gbf_pkg.sv
// Shared definitions for the global-buffer loader and controller:
// FSM encoding, buffer identifiers and default widths.
package gbf_pkg;

  localparam int GBF_DATA_BW_DEF = 256;
  localparam int GBF_ADDR_BW_DEF = 5;
  localparam int GBF_DEPTH_DEF   = 32;
  localparam int TILE_CNT_BW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    FILL   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    BUF1 = 1'b0,
    BUF2 = 1'b1
  } buf_t;

  function automatic buf_t other_buf(input buf_t b);
    return (b == BUF1) ? BUF2 : BUF1;
  endfunction

endpackage

// File: rtl/gbf_wr_port.sv
// Registered port-a write demux: one accepted stream word becomes a write
// on the selected buffer's port in the following cycle.
module gbf_wr_port
  import gbf_pkg::*;
#(
  parameter int DATA_W = GBF_DATA_BW_DEF,
  parameter int ADDR_W = GBF_ADDR_BW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  buf_t              sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              en1a,
  output logic              we1a,
  output logic [ADDR_W-1:0] addr1a,
  output logic [DATA_W-1:0] w_data1a,
  output logic              en2a,
  output logic              we2a,
  output logic [ADDR_W-1:0] addr2a,
  output logic [DATA_W-1:0] w_data2a
);

  logic wr1, wr2;

  assign wr1 = wr && (sel == BUF1);
  assign wr2 = wr && (sel == BUF2);

  always_ff @(posedge clk) begin
    if (reset) begin
      en1a     <= 1'b0;
      we1a     <= 1'b0;
      addr1a   <= '0;
      w_data1a <= '0;
      en2a     <= 1'b0;
      we2a     <= 1'b0;
      addr2a   <= '0;
      w_data2a <= '0;
    end else begin
      en1a <= wr1;
      we1a <= wr1;
      en2a <= wr2;
      we2a <= wr2;
      // address/data hold their last written value between writes
      if (wr1) begin
        addr1a   <= addr;
        w_data1a <= data;
      end
      if (wr2) begin
        addr2a   <= addr;
        w_data2a <= data;
      end
    end
  end

endmodule

// File: rtl/gbf_loader.sv
// Streams tiles into a double-buffered global buffer, filling whichever
// buffer the controller requests and flagging it ready when complete.
module gbf_loader
  import gbf_pkg::*;
#(
  parameter int GBF_DATA_BITWIDTH = GBF_DATA_BW_DEF,
  parameter int GBF_ADDR_BITWIDTH = GBF_ADDR_BW_DEF,
  parameter int GBF_DEPTH         = GBF_DEPTH_DEF,
  parameter int TILE_CNT_BITWIDTH = TILE_CNT_BW_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [TILE_CNT_BITWIDTH-1:0] cfg_num_tiles,
  input  logic [GBF_ADDR_BITWIDTH:0]   cfg_fill_words,
  input  logic                         s_valid,
  input  logic [GBF_DATA_BITWIDTH-1:0] s_data,
  output logic                         s_ready,
  input  logic                         need_data1,
  input  logic                         need_data2,
  output logic                         en1a,
  output logic                         we1a,
  output logic                         en2a,
  output logic                         we2a,
  output logic [GBF_ADDR_BITWIDTH-1:0] addr1a,
  output logic [GBF_ADDR_BITWIDTH-1:0] addr2a,
  output logic [GBF_DATA_BITWIDTH-1:0] w_data1a,
  output logic [GBF_DATA_BITWIDTH-1:0] w_data2a,
  output logic                         buf1_ready,
  output logic                         buf2_ready,
  output logic                         data_avail,
  output logic                         busy
);

  localparam int FW = GBF_ADDR_BITWIDTH + 1;

  state_t                         state, state_n;
  logic [TILE_CNT_BITWIDTH-1:0]   num_tiles, tile_cnt;
  logic [FW-1:0]                  fill_words;
  logic [GBF_ADDR_BITWIDTH-1:0]   word_cnt;
  buf_t                           cur_buf, nxt_buf, sel_buf;
  logic                           rel1, rel2;
  logic                           elig1, elig2, sel_go, hs, last, final_tile;

  // A ready buffer becomes refillable only after its need has dropped and
  // risen again, so a need held high across a completed tile never refills it.
  assign elig1 = need_data1 && (!buf1_ready || rel1);
  assign elig2 = need_data2 && (!buf2_ready || rel2);

  assign s_ready    = (state == FILL);
  assign busy       = (state != IDLE);
  assign hs         = s_valid && s_ready;
  assign last       = hs && (({1'b0, word_cnt} == fill_words - FW'(1)) ||
                             ({1'b0, word_cnt} == FW'(GBF_DEPTH - 1)));
  assign final_tile = ((tile_cnt + TILE_CNT_BITWIDTH'(1)) == num_tiles);

  always_comb begin
    state_n = state;
    sel_go  = 1'b0;
    sel_buf = nxt_buf;
    unique case (state)
      IDLE:   if (start) state_n = (cfg_num_tiles == '0) ? DONE : SELECT;
      SELECT: begin
        if (elig1 && elig2) begin
          sel_go  = 1'b1;
          sel_buf = nxt_buf;
        end else if (elig1) begin
          sel_go  = 1'b1;
          sel_buf = BUF1;
        end else if (elig2) begin
          sel_go  = 1'b1;
          sel_buf = BUF2;
        end
        if (sel_go) state_n = FILL;
      end
      FILL:   if (last) state_n = final_tile ? DONE : SELECT;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      num_tiles  <= '0;
      fill_words <= '0;
      tile_cnt   <= '0;
      word_cnt   <= '0;
      cur_buf    <= BUF1;
      nxt_buf    <= BUF1;
      buf1_ready <= 1'b0;
      buf2_ready <= 1'b0;
      rel1       <= 1'b0;
      rel2       <= 1'b0;
      data_avail <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        num_tiles  <= cfg_num_tiles;
        fill_words <= cfg_fill_words;
        tile_cnt   <= '0;
        data_avail <= (cfg_num_tiles != '0);
      end
      if (sel_go) begin
        cur_buf  <= sel_buf;
        nxt_buf  <= other_buf(sel_buf);
        word_cnt <= '0;
      end
      if (hs) word_cnt <= word_cnt + GBF_ADDR_BITWIDTH'(1);
      if (last) begin
        tile_cnt <= tile_cnt + TILE_CNT_BITWIDTH'(1);
        if (final_tile) data_avail <= 1'b0;
      end
      if (sel_go && sel_buf == BUF1)     buf1_ready <= 1'b0;
      else if (last && cur_buf == BUF1)  buf1_ready <= 1'b1;
      if (sel_go && sel_buf == BUF2)     buf2_ready <= 1'b0;
      else if (last && cur_buf == BUF2)  buf2_ready <= 1'b1;
      if (sel_go && sel_buf == BUF1)     rel1 <= 1'b0;
      else if (buf1_ready && !need_data1) rel1 <= 1'b1;
      if (sel_go && sel_buf == BUF2)     rel2 <= 1'b0;
      else if (buf2_ready && !need_data2) rel2 <= 1'b1;
    end
  end

  gbf_wr_port #(
    .DATA_W (GBF_DATA_BITWIDTH),
    .ADDR_W (GBF_ADDR_BITWIDTH)
  ) u_wr_port (
    .clk      (clk),
    .reset    (reset),
    .wr       (hs),
    .sel      (cur_buf),
    .addr     (word_cnt),
    .data     (s_data),
    .en1a     (en1a),
    .we1a     (we1a),
    .addr1a   (addr1a),
    .w_data1a (w_data1a),
    .en2a     (en2a),
    .we2a     (we2a),
    .addr2a   (addr2a),
    .w_data2a (w_data2a)
  );

endmodule

// File: tb/tb_gbf_loader.sv
// Directed, self-checking bench for gbf_loader: single tile, ping-pong,
// stalls, zero tiles, reset mid-fill and full-depth fill.
module tb_gbf_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [15:0]  cfg_num_tiles;
  logic [5:0]   cfg_fill_words;
  logic         s_valid;
  logic [255:0] s_data;
  logic         s_ready;
  logic         need_data1, need_data2;
  logic         en1a, we1a, en2a, we2a;
  logic [4:0]   addr1a, addr2a;
  logic [255:0] w_data1a, w_data2a;
  logic         buf1_ready, buf2_ready, data_avail, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gbf_loader #(
    .GBF_DATA_BITWIDTH (256),
    .GBF_ADDR_BITWIDTH (5),
    .GBF_DEPTH         (32),
    .TILE_CNT_BITWIDTH (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cfg_num_tiles  (cfg_num_tiles),
    .cfg_fill_words (cfg_fill_words),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .need_data1     (need_data1),
    .need_data2     (need_data2),
    .en1a           (en1a),
    .we1a           (we1a),
    .en2a           (en2a),
    .we2a           (we2a),
    .addr1a         (addr1a),
    .addr2a         (addr2a),
    .w_data1a       (w_data1a),
    .w_data2a       (w_data2a),
    .buf1_ready     (buf1_ready),
    .buf2_ready     (buf2_ready),
    .data_avail     (data_avail),
    .busy           (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; cfg_num_tiles = '0; cfg_fill_words = '0;
    s_valid = 1'b0; s_data = '0; need_data1 = 1'b0; need_data2 = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic launch(input logic [15:0] n, input logic [5:0] fw);
    cfg_num_tiles = n; cfg_fill_words = fw; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({s_ready, en1a, we1a, en2a, we2a, buf1_ready, buf2_ready, data_avail, busy} !== 9'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 000000000",
               {s_ready, en1a, we1a, en2a, we2a, buf1_ready, buf2_ready, data_avail, busy});
    end
    tests++;
    if ({addr1a, addr2a} !== 10'b0) begin
      fails++; $display("FAIL reset_addr: got %h want 0", {addr1a, addr2a});
    end
    tests++;
    if ((w_data1a | w_data2a) !== 256'b0) begin
      fails++; $display("FAIL reset_wdata: got %h/%h want 0", w_data1a, w_data2a);
    end
  endtask

  task automatic test_single_tile();
    do_reset();
    need_data1 = 1'b1;
    launch(16'd1, 6'd4);
    tests++;
    if ({busy, data_avail, s_ready} !== 3'b110) begin
      fails++; $display("FAIL single_select: got busy/avail/ready=%b want 110", {busy, data_avail, s_ready});
    end
    step();
    tests++;
    if (s_ready !== 1'b1) begin
      fails++; $display("FAIL single_fill_ready: got %b want 1", s_ready);
    end
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 256'(8'hA0 + i);
      step();
      tests++;
      if ({en1a, we1a, en2a, we2a} !== 4'b1100 || addr1a !== 5'(i) || w_data1a !== 256'(8'hA0 + i)) begin
        fails++;
        $display("FAIL single_write[%0d]: got en/we=%b addr=%0d data=%h want 1100 addr=%0d data=%h",
                 i, {en1a, we1a, en2a, we2a}, addr1a, w_data1a[7:0], i, 8'hA0 + i);
      end
      tests++;
      if (buf1_ready !== (i == 3) || data_avail !== (i != 3)) begin
        fails++;
        $display("FAIL single_flags[%0d]: got ready=%b avail=%b want ready=%b avail=%b",
                 i, buf1_ready, data_avail, i == 3, i != 3);
      end
    end
    tests++;
    if ({s_ready, busy} !== 2'b01) begin
      fails++; $display("FAIL single_done: got ready/busy=%b want 01", {s_ready, busy});
    end
    s_valid = 1'b0;
    step();
    tests++;
    if ({en1a, en2a, busy, buf1_ready} !== 4'b0001) begin
      fails++; $display("FAIL single_idle: got en1/en2/busy/rdy=%b want 0001", {en1a, en2a, busy, buf1_ready});
    end
  endtask

  task automatic test_ping_pong();
    do_reset();
    need_data1 = 1'b1; need_data2 = 1'b1;
    launch(16'd3, 6'd2);
    step();
    s_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_data = 256'(8'hB0 + i);
      step();
      tests++;
      if ({en1a, en2a} !== 2'b10 || addr1a !== 5'(i) || w_data1a !== 256'(8'hB0 + i)) begin
        fails++; $display("FAIL pp_tile0[%0d]: got en=%b addr=%0d data=%h want 10 addr=%0d", i, {en1a, en2a}, addr1a, w_data1a[7:0], i);
      end
    end
    tests++;
    if ({buf1_ready, buf2_ready, data_avail, s_ready} !== 4'b1010) begin
      fails++; $display("FAIL pp_after0: got rdy1/rdy2/avail/sready=%b want 1010", {buf1_ready, buf2_ready, data_avail, s_ready});
    end
    s_data = 256'(8'hC0);
    step();
    tests++;
    if ({en1a, en2a, s_ready, buf1_ready} !== 4'b0011) begin
      fails++; $display("FAIL pp_select1: got en1/en2/sready/rdy1=%b want 0011", {en1a, en2a, s_ready, buf1_ready});
    end
    for (int i = 0; i < 2; i++) begin
      s_data = 256'(8'hC0 + i);
      step();
      tests++;
      if ({en1a, en2a} !== 2'b01 || addr2a !== 5'(i) || w_data2a !== 256'(8'hC0 + i)) begin
        fails++; $display("FAIL pp_tile1[%0d]: got en=%b addr=%0d data=%h want 01 addr=%0d", i, {en1a, en2a}, addr2a, w_data2a[7:0], i);
      end
    end
    tests++;
    if ({buf1_ready, buf2_ready, data_avail} !== 3'b111) begin
      fails++; $display("FAIL pp_after1: got rdy1/rdy2/avail=%b want 111", {buf1_ready, buf2_ready, data_avail});
    end
    s_data = 256'(8'hD0);
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({s_ready, en1a, en2a, busy} !== 4'b0001) begin
        fails++; $display("FAIL pp_wait[%0d]: got sready/en1/en2/busy=%b want 0001", i, {s_ready, en1a, en2a, busy});
      end
    end
    need_data1 = 1'b0;
    step();
    tests++;
    if ({s_ready, buf1_ready} !== 2'b01) begin
      fails++; $display("FAIL pp_drop: got sready/rdy1=%b want 01", {s_ready, buf1_ready});
    end
    need_data1 = 1'b1;
    step();
    tests++;
    if ({s_ready, buf1_ready, buf2_ready} !== 3'b101) begin
      fails++; $display("FAIL pp_reselect: got sready/rdy1/rdy2=%b want 101", {s_ready, buf1_ready, buf2_ready});
    end
    for (int i = 0; i < 2; i++) begin
      s_data = 256'(8'hD0 + i);
      step();
      tests++;
      if ({en1a, en2a} !== 2'b10 || addr1a !== 5'(i) || w_data1a !== 256'(8'hD0 + i)) begin
        fails++; $display("FAIL pp_tile2[%0d]: got en=%b addr=%0d data=%h want 10 addr=%0d", i, {en1a, en2a}, addr1a, w_data1a[7:0], i);
      end
    end
    tests++;
    if ({buf1_ready, buf2_ready, data_avail, busy} !== 4'b1101) begin
      fails++; $display("FAIL pp_end: got rdy1/rdy2/avail/busy=%b want 1101", {buf1_ready, buf2_ready, data_avail, busy});
    end
    s_valid = 1'b0;
    step();
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL pp_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_stalls();
    logic [6:0] pat;
    int k;
    pat = 7'b1011001;
    k = 0;
    do_reset();
    need_data1 = 1'b1;
    launch(16'd1, 6'd4);
    step();
    for (int i = 0; i < 7; i++) begin
      s_valid = pat[i];
      s_data  = 256'(8'hE0 + i);
      step();
      tests++;
      if (en1a !== pat[i] || en2a !== 1'b0) begin
        fails++; $display("FAIL stall_en[%0d]: got en1=%b en2=%b want %b 0", i, en1a, en2a, pat[i]);
      end else if (pat[i]) begin
        tests++;
        if (addr1a !== 5'(k) || w_data1a !== 256'(8'hE0 + i)) begin
          fails++; $display("FAIL stall_write[%0d]: got addr=%0d data=%h want addr=%0d data=%h", i, addr1a, w_data1a[7:0], k, 8'hE0 + i);
        end
        k++;
      end
    end
    tests++;
    if (k !== 4 || buf1_ready !== 1'b1) begin
      fails++; $display("FAIL stall_count: got writes=%0d ready=%b want 4 1", k, buf1_ready);
    end
    s_valid = 1'b0;
    step();
  endtask

  task automatic test_zero_tiles();
    do_reset();
    need_data1 = 1'b1; s_valid = 1'b1;
    launch(16'd0, 6'd4);
    tests++;
    if ({busy, data_avail, s_ready, en1a} !== 4'b1000) begin
      fails++; $display("FAIL zero_done: got busy/avail/sready/en1=%b want 1000", {busy, data_avail, s_ready, en1a});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({busy, data_avail, s_ready, en1a, en2a} !== 5'b0) begin
        fails++; $display("FAIL zero_idle[%0d]: got busy/avail/sready/en1/en2=%b want 00000", i, {busy, data_avail, s_ready, en1a, en2a});
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    need_data1 = 1'b1;
    launch(16'd1, 6'd4);
    step();
    s_valid = 1'b1;
    s_data = 256'(8'hF0); step();
    s_data = 256'(8'hF1); step();
    reset = 1'b1;
    step();
    tests++;
    if ({s_ready, en1a, we1a, en2a, busy, data_avail, buf1_ready} !== 7'b0 ||
        addr1a !== 5'd0 || w_data1a !== 256'b0) begin
      fails++; $display("FAIL midrst_clear: got flags=%b addr=%0d data=%h want 0",
                        {s_ready, en1a, we1a, en2a, busy, data_avail, buf1_ready}, addr1a, w_data1a[7:0]);
    end
    reset = 1'b0; s_valid = 1'b0; need_data2 = 1'b1;
    launch(16'd1, 6'd4);
    step();
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 256'(8'h50 + i);
      step();
      tests++;
      if ({en1a, en2a} !== 2'b10 || addr1a !== 5'(i) || w_data1a !== 256'(8'h50 + i)) begin
        fails++; $display("FAIL midrst_refill[%0d]: got en=%b addr=%0d data=%h want 10 addr=%0d", i, {en1a, en2a}, addr1a, w_data1a[7:0], i);
      end
    end
    tests++;
    if ({buf1_ready, buf2_ready} !== 2'b10) begin
      fails++; $display("FAIL midrst_ready: got rdy1/rdy2=%b want 10", {buf1_ready, buf2_ready});
    end
    s_valid = 1'b0;
    step();
  endtask

  task automatic test_full_depth();
    do_reset();
    need_data2 = 1'b1;
    launch(16'd1, 6'd32);
    step();
    s_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      s_data = 256'(i);
      step();
      tests++;
      if ({en2a, we2a, en1a} !== 3'b110 || addr2a !== 5'(i) || w_data2a !== 256'(i) || buf2_ready !== (i == 31)) begin
        fails++; $display("FAIL full_write[%0d]: got en/we/en1=%b addr=%0d ready=%b want 110 addr=%0d ready=%b",
                          i, {en2a, we2a, en1a}, addr2a, buf2_ready, i, i == 31);
      end
    end
    step();
    tests++;
    if ({en1a, en2a, s_ready, buf2_ready, data_avail} !== 5'b00010) begin
      fails++; $display("FAIL full_after: got en1/en2/sready/rdy2/avail=%b want 00010", {en1a, en2a, s_ready, buf2_ready, data_avail});
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_tile();
    test_ping_pong();
    test_stalls();
    test_zero_tiles();
    test_reset_mid_fill();
    test_full_depth();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
